block_byte_scheduler: RTL
=========================

# block_byte_scheduler

Ping-pong playout scheduler between the block-based cipher path and the 12 kHz sample-rate audio path. Accepts whole 16-byte blocks (cipher or decipher output) into two buffer slots and emits one byte per sample tick to the volume control / PDM or transmit stage. Handles block-rate to sample-rate rate matching, underrun (silence), and overrun (block drop).

## Interface
- NUM_BYTES, 16, bytes per block; power of two, ≥2
- WIDTH, 8, bits per byte/sample
- clk_in  input  1  system clock (98.3 MHz domain)
- rst_in  input  1  asynchronous, active-high reset
- block_valid_in  input  1  single-cycle strobe: block_in holds a complete block
- block_in  input  [NUM_BYTES-1:0][WIDTH-1:0]  block data; byte 0 played first
- block_ready_out  output  1  high when at least one slot is free
- tick_in  input  1  single-cycle sample strobe (~12 kHz, fourth FIR stage valid)
- byte_out  output  WIDTH  current sample, signed two's complement
- byte_valid_out  output  1  single-cycle strobe, one per tick_in
- underrun_out  output  1  single-cycle strobe: tick arrived with no data buffered
- overrun_out  output  1  single-cycle strobe: block dropped, both slots full
- busy_out  output  1  high while state is PLAY

## Operation
- Storage: two slots of NUM_BYTES×WIDTH; write pointer wr_sel, read pointer rd_sel, fill count cnt (0..2), byte index idx ($clog2(NUM_BYTES) bits).
- block_ready_out = (cnt != 2), registered-state derived only; no combinational path from tick_in.
- Load: block_valid_in && cnt != 2 → copy block_in into slot wr_sel, toggle wr_sel, cnt+1.
- Overrun: block_valid_in && cnt == 2 → block discarded, overrun_out pulses; no state change. Holds even if a slot is released in the same cycle.
- States: IDLE (cnt == 0, idx == 0), PLAY (a slot is being drained).
- IDLE → PLAY when cnt becomes nonzero; the tick that arrives on the load cycle still counts as underrun.
- PLAY, tick_in: byte_out ← slot[rd_sel][idx]; byte_valid_out pulses; idx+1. At idx == NUM_BYTES-1: idx wraps to 0, rd_sel toggles, cnt−1; PLAY → IDLE if the resulting cnt == 0.
- Simultaneous load and release in one cycle: cnt is unchanged (+1−1); both pointers advance.
- Underrun: tick_in with cnt == 0 → byte_valid_out and underrun_out pulse; byte_out = 0 (silence); the sample rate at the output stays continuous.
- Bytes are passed through unmodified; no arithmetic on data.

## Timing
- Reset (async, immediate): byte_out=0, byte_valid_out=0, underrun_out=0, overrun_out=0, busy_out=0, block_ready_out=1. Slots are not cleared; cnt/idx/pointers = 0; state IDLE.
- Reset mid-playout discards all buffered data; the first tick after release is an underrun.
- byte_out and byte_valid_out are registered: valid the cycle after tick_in, and byte_out holds until the next tick.
- Load latency: a block accepted on cycle N is playable by a tick at N+1 or later.
- Strobes are exactly one clk_in cycle wide. tick_in is ignored in the cycle it coincides with rst_in.
- Steady state at 12 kHz: one block consumed per NUM_BYTES ticks (1.33 ms at 16 bytes).

## Configuration
- SCHED_UNDERRUN_HOLD_EN defined: on underrun, byte_out repeats the last emitted byte (0 after reset) instead of 0; underrun_out still pulses.
- Not defined: underrun emits 0 as described above.

## Test plan
- Reset, then 4 ticks with no block → 4 byte_valid_out pulses with byte_out=0, 4 underrun_out pulses, busy_out=0.
- Load block bytes 0x00..0x0F, then 16 ticks → byte_out 0x00..0x0F in order, busy_out falls after the 16th tick, block_ready_out high throughout.
- Load blocks A (0xA0..0xAF) and B (0xB0..0xBF), then a third block C → block_ready_out=0 after B, overrun_out pulses once, playout is A then B with no C bytes, then underrun.
- Load block with byte 15 = 0x7F; on the cycle of the 16th tick, assert block_valid_in with cnt=1 → block accepted, cnt stays 1, next tick plays the new block's byte 0.
- Assert rst_in after 5 of 16 bytes are played → all outputs go to reset values immediately; next tick gives underrun with byte_out=0.
- With SCHED_UNDERRUN_HOLD_EN: play block ending 0x5A, then 2 ticks → byte_out=0x5A twice with underrun_out pulses.

Source files
------------

// File: rtl/block_byte_scheduler_if.sv
// -----------------------------------------------------------------------------
// block_byte_scheduler_if
//
// Purpose : bundles the block-input handshake and the per-sample output of
//           block_byte_scheduler so the scheduler and its neighbours connect
//           through a single port.
//
// Signals :
//   block_valid_in   single-cycle strobe, block_in carries a complete block
//   block_in         NUM_BYTES x WIDTH block, byte 0 is played first
//   block_ready_out  at least one of the two buffer slots is free
//   tick_in          single-cycle sample strobe (~12 kHz)
//   byte_out         current sample, signed two's complement
//   byte_valid_out   single-cycle strobe, one per tick_in
//   underrun_out     single-cycle strobe, tick arrived with nothing buffered
//   overrun_out      single-cycle strobe, block dropped with both slots full
//   busy_out         scheduler is draining a slot
//
// Modports: master = block source / tick source / sample sink side,
//           slave  = the scheduler itself.
// -----------------------------------------------------------------------------
interface block_byte_scheduler_if #(
   parameter int NUM_BYTES = 16,
   parameter int WIDTH     = 8
);
   logic                                block_valid_in;
   logic [NUM_BYTES-1:0][WIDTH-1:0]     block_in;
   logic                                block_ready_out;
   logic                                tick_in;
   logic [WIDTH-1:0]                    byte_out;
   logic                                byte_valid_out;
   logic                                underrun_out;
   logic                                overrun_out;
   logic                                busy_out;

   modport master (
      output block_valid_in,
      output block_in,
      output tick_in,
      input  block_ready_out,
      input  byte_out,
      input  byte_valid_out,
      input  underrun_out,
      input  overrun_out,
      input  busy_out
   );

   modport slave (
      input  block_valid_in,
      input  block_in,
      input  tick_in,
      output block_ready_out,
      output byte_out,
      output byte_valid_out,
      output underrun_out,
      output overrun_out,
      output busy_out
   );
endinterface

// File: rtl/block_byte_scheduler.sv
// -----------------------------------------------------------------------------
// block_byte_scheduler
//
// Purpose : ping-pong playout buffer between the block-based cipher path and
//           the 12 kHz audio path. Whole NUM_BYTES-byte blocks are written into
//           one of two slots; one byte is emitted per sample tick. An empty
//           buffer produces silence (underrun), a full buffer drops incoming
//           blocks (overrun).
//
// Ports   :
//   clk_in   system clock
//   rst_in   asynchronous, active-high reset
//   bus      block_byte_scheduler_if.slave (block input, tick input,
//            byte/strobe outputs, ready and busy status)
//
// Parameters: NUM_BYTES (power of two, >= 2), WIDTH (bits per byte). They must
//           match the parameters of the connected interface instance.
//
// Build option: define SCHED_UNDERRUN_HOLD_EN to repeat the last emitted byte
//           on underrun instead of emitting 0.
// -----------------------------------------------------------------------------
module block_byte_scheduler #(
   parameter int NUM_BYTES = 16,
   parameter int WIDTH     = 8
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   block_byte_scheduler_if.slave       bus
);

   localparam int                IDX_W    = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_BYTES - 1);

   localparam logic [0:0]        ST_IDLE  = 1'b0;
   localparam logic [0:0]        ST_PLAY  = 1'b1;

   typedef logic [NUM_BYTES-1:0][WIDTH-1:0] block_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [0:0]          state_reg,      state_next;
   logic [1:0]          cnt_reg,        cnt_next;
   logic                wr_sel_reg,     wr_sel_next;
   logic                rd_sel_reg,     rd_sel_next;
   logic [IDX_W-1:0]    idx_reg,        idx_next;
   logic [WIDTH-1:0]    byte_reg,       byte_next;
   logic                byte_valid_reg, byte_valid_next;
   logic                underrun_reg,   underrun_next;
   logic                overrun_reg,    overrun_next;

   // ---------------------------------------------------------------------------
   // Per-cycle decisions, all taken from registered state so that neither the
   // ready flag nor the drop decision depends combinationally on tick_in.
   // ---------------------------------------------------------------------------
   logic                load_en;
   logic                drop_en;
   logic                play_en;
   logic                silence_en;
   logic                release_en;
   logic [WIDTH-1:0]    rd_byte;

   assign load_en    = bus.block_valid_in && (cnt_reg != 2'd2);
   // A full buffer drops the block even when a slot frees up this same cycle.
   assign drop_en    = bus.block_valid_in && (cnt_reg == 2'd2);
   assign play_en    = bus.tick_in && (state_reg == ST_PLAY);
   // A block loaded this cycle is not yet visible: cnt_reg is still 0 here.
   assign silence_en = bus.tick_in && (state_reg == ST_IDLE);
   assign release_en = play_en && (idx_reg == IDX_LAST);

   // ---------------------------------------------------------------------------
   // Slot storage. No reset: contents are only ever read after a load has
   // marked the slot as filled, so stale data is never played.
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         block_t data_reg;

         always_ff @(posedge clk_in) begin
            if (load_en && (wr_sel_reg == 1'(gi))) begin
               data_reg <= bus.block_in;
            end
         end
      end
   endgenerate

   assign rd_byte = rd_sel_reg ? g_slot[1].data_reg[idx_reg]
                               : g_slot[0].data_reg[idx_reg];

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      cnt_next        = cnt_reg;
      wr_sel_next     = wr_sel_reg;
      rd_sel_next     = rd_sel_reg;
      idx_next        = idx_reg;
      byte_next       = byte_reg;
      byte_valid_next = 1'b0;
      underrun_next   = 1'b0;
      overrun_next    = drop_en;

      // Fill count: a load and a release in the same cycle cancel out, but
      // both pointers still advance.
      case ({load_en, release_en})
         2'b10:   cnt_next = cnt_reg + 2'd1;
         2'b01:   cnt_next = cnt_reg - 2'd1;
         default: cnt_next = cnt_reg;
      endcase

      if (load_en) begin
         wr_sel_next = ~wr_sel_reg;
      end

      if (play_en) begin
         byte_next       = rd_byte;
         byte_valid_next = 1'b1;
         if (release_en) begin
            idx_next    = '0;
            rd_sel_next = ~rd_sel_reg;
         end else begin
            idx_next    = idx_reg + 1'b1;
         end
      end else if (silence_en) begin
         // Keep the output sample rate continuous even with nothing buffered.
         byte_valid_next = 1'b1;
         underrun_next   = 1'b1;
`ifdef SCHED_UNDERRUN_HOLD_EN
         byte_next       = byte_reg;
`else
         byte_next       = '0;
`endif
      end

      state_next = (cnt_next != 2'd0) ? ST_PLAY : ST_IDLE;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= 2'd0;
         wr_sel_reg     <= 1'b0;
         rd_sel_reg     <= 1'b0;
         idx_reg        <= '0;
         byte_reg       <= '0;
         byte_valid_reg <= 1'b0;
         underrun_reg   <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         wr_sel_reg     <= wr_sel_next;
         rd_sel_reg     <= rd_sel_next;
         idx_reg        <= idx_next;
         byte_reg       <= byte_next;
         byte_valid_reg <= byte_valid_next;
         underrun_reg   <= underrun_next;
         overrun_reg    <= overrun_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.block_ready_out = (cnt_reg != 2'd2);
   assign bus.byte_out        = byte_reg;
   assign bus.byte_valid_out  = byte_valid_reg;
   assign bus.underrun_out    = underrun_reg;
   assign bus.overrun_out     = overrun_reg;
   assign bus.busy_out        = (state_reg == ST_PLAY);

endmodule
